// File: rtl/sync_ram_pipe.sv
// 1R1W byte-enable RAM with pipelined, credit-controlled read responses.
// Define SYNC_RAM_PIPE_PARITY_EN to store and check one even-parity bit per byte.
module sync_ram_pipe #(
  parameter int    ADDR_WIDTH   = 12,
  parameter int    DATA_WIDTH   = 32,
  parameter int    DEPTH        = 2 ** (ADDR_WIDTH - $clog2(DATA_WIDTH / 8)),
  parameter int    READ_LATENCY = 2,
  parameter bit    WRITE_FIRST  = 1'b0,
  parameter string MEM_HEX      = ""
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [ADDR_WIDTH-1:0]   req_addr,
  input  logic                    wr_valid,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH/8-1:0] wr_strb,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic                    wr_inj_err,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic [DATA_WIDTH-1:0]   resp_data,
  output logic                    resp_err
);

  localparam int BYTES = DATA_WIDTH / 8;
  localparam int OFF   = $clog2(BYTES);
  localparam int WA    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FD    = READ_LATENCY + 1;
  localparam int PW    = $clog2(FD);
  localparam int CW    = $clog2(FD + 1);

  function automatic logic [BYTES-1:0] byte_par(input logic [DATA_WIDTH-1:0] d);
    logic [BYTES-1:0] p;
    p = '0;
    for (int i = 0; i < BYTES; i++) p[i] = ^d[i*8 +: 8];
    return p;
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FD - 1)) ? '0 : p + PW'(1);
  endfunction

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [WA-1:0]         rd_idx, wr_idx;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_err;
  logic                  accept, pop, push, fifo_pop, fifo_empty;

  logic [DATA_WIDTH-1:0]   pipe_data [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipe_valid, pipe_err;
  logic [DATA_WIDTH-1:0]   fifo_data [FD];
  logic [FD-1:0]           fifo_err;
  logic [PW-1:0]           wr_ptr, rd_ptr;
  logic [CW-1:0]           fifo_cnt, outstanding;
  logic [DATA_WIDTH-1:0]   head_data;
  logic                    head_err, last_valid;

  logic unused_addr;
  assign unused_addr = ^{req_addr, wr_addr};

  assign rd_idx = req_addr[OFF +: WA];
  assign wr_idx = wr_addr[OFF +: WA];

`ifdef SYNC_RAM_PIPE_PARITY_EN
  logic [BYTES-1:0] par_mem [DEPTH];
  logic [BYTES-1:0] wr_par, rd_par;
  assign wr_par = byte_par(wr_data) ^ {BYTES{wr_inj_err}};
`else
  logic unused_inj;
  assign unused_inj = wr_inj_err;
`endif

  // Power-up contents: zero fill.
  initial begin
    for (int i = 0; i < DEPTH; i++) mem[i] = '0;
`ifdef SYNC_RAM_PIPE_PARITY_EN
    for (int i = 0; i < DEPTH; i++) par_mem[i] = byte_par(mem[i]);
`endif
  end

  always @(posedge clock) begin
    if (wr_valid) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wr_strb[i]) begin
          mem[wr_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
`ifdef SYNC_RAM_PIPE_PARITY_EN
          par_mem[wr_idx][i] <= wr_par[i];
`endif
        end
      end
    end
  end

  // Array read is old data; write-first mode patches in the strobed bytes.
  always_comb begin
    rd_word = mem[rd_idx];
`ifdef SYNC_RAM_PIPE_PARITY_EN
    rd_par = par_mem[rd_idx];
`endif
    if (WRITE_FIRST && wr_valid && (wr_idx == rd_idx)) begin
      for (int i = 0; i < BYTES; i++) begin
        if (wr_strb[i]) begin
          rd_word[i*8 +: 8] = wr_data[i*8 +: 8];
`ifdef SYNC_RAM_PIPE_PARITY_EN
          rd_par[i] = wr_par[i];
`endif
        end
      end
    end
`ifdef SYNC_RAM_PIPE_PARITY_EN
    rd_err = |(rd_par ^ byte_par(rd_word));
`else
    rd_err = 1'b0;
`endif
  end

  assign req_ready  = reset_n && (outstanding < CW'(FD));
  assign accept     = req_valid && req_ready;
  assign last_valid = pipe_valid[READ_LATENCY-1];
  assign fifo_empty = (fifo_cnt == '0);
  assign resp_valid = !fifo_empty || last_valid;
  assign pop        = resp_valid && resp_ready;
  // An arriving word consumed straight from the bypass never enters the FIFO.
  assign push       = last_valid && !(fifo_empty && pop);
  assign fifo_pop   = pop && !fifo_empty;

  assign head_data = fifo_empty ? pipe_data[READ_LATENCY-1] : fifo_data[rd_ptr];
  assign head_err  = fifo_empty ? pipe_err[READ_LATENCY-1]  : fifo_err[rd_ptr];
  assign resp_data = resp_valid ? head_data : '0;
  assign resp_err  = resp_valid && head_err;

  always_ff @(posedge clock) begin
    pipe_data[0] <= rd_word;
    pipe_err[0]  <= rd_err;
    for (int s = 1; s < READ_LATENCY; s++) begin
      pipe_data[s] <= pipe_data[s-1];
      pipe_err[s]  <= pipe_err[s-1];
    end
    if (push) begin
      fifo_data[wr_ptr] <= pipe_data[READ_LATENCY-1];
      fifo_err[wr_ptr]  <= pipe_err[READ_LATENCY-1];
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pipe_valid  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      fifo_cnt    <= '0;
      outstanding <= '0;
    end else begin
      pipe_valid[0] <= accept;
      for (int s = 1; s < READ_LATENCY; s++) pipe_valid[s] <= pipe_valid[s-1];
      if (push)     wr_ptr <= ptr_inc(wr_ptr);
      if (fifo_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, fifo_pop})
        2'b10:   fifo_cnt <= fifo_cnt + CW'(1);
        2'b01:   fifo_cnt <= fifo_cnt - CW'(1);
        default: fifo_cnt <= fifo_cnt;
      endcase
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule
